snap_trig_capture: RTL and testbench
====================================

# snap_trig_capture

Capture controller for a snapshot block. It sits directly downstream of the software trigger-offset register and consumes its 32-bit `user_data_out` value as `trig_offset`. On an arm request it waits for a sample-aligned trigger and writes a window of 2^AW valid samples into a simple-dual-port BRAM. A positive offset delays the window past the trigger; a negative offset captures pre-trigger history through a circular buffer. It reports completion and the oldest-sample address back to software status registers.

## Interface
- `AW`, 10: BRAM address width; DEPTH = 2^AW samples.
- `DW`, 32: sample width.

Ports:
- `user_clk`  in  1  sole clock; all logic on rising edge.
- `user_rst_n`  in  1  asynchronous, active-low reset.
- `arm`  in  1  level from the control register; a rising edge starts a capture.
- `trig_offset`  in  32  signed offset, taken from the offset register's `user_data_out`.
- `trig`  in  1  trigger; only counts when `din_we` is high in the same cycle.
- `din_we`  in  1  sample valid.
- `din`  in  DW  sample data.
- `bram_we`  out  1  BRAM write strobe.
- `bram_addr`  out  AW  BRAM write address.
- `bram_data`  out  DW  BRAM write data.
- `status_done`  out  1  capture complete.
- `status_addr`  out  AW  address of the oldest valid sample (the next write position).

## Operation
- States and transitions:
  - IDLE: wait for an arm edge.
  - ARMED: wait for a trigger, writing circularly if the offset is negative.
  - DELAY: skip samples for a positive offset.
  - CAPTURE: write the post-trigger window.
  - DONE: hold results.
- Arm edge:
  - Detected as `arm` high this cycle and low the previous cycle.
  - Valid from any state: latches `trig_offset`, clears the write address, fill count and `status_done`, then enters ARMED.
  - Software changes to `trig_offset` after the arm edge have no effect on the current capture.
- Offset == 0:
  - The trigger sample is written at address 0; enter CAPTURE.
  - Remaining count = DEPTH-1.
- Offset > 0:
  - Enter DELAY on the trigger sample. That sample, and the following offset-1 valid samples, are discarded.
  - The first stored sample is trigger index + offset.
  - Then CAPTURE with remaining count = DEPTH.
- Offset < 0:
  - PRE = min(|offset|, DEPTH-1).
  - In ARMED, every valid sample is written at an incrementing address that wraps at DEPTH. A fill counter saturates at PRE.
  - A trigger is ignored until the fill count has reached PRE.
  - An accepted trigger sample is written; then enter CAPTURE with remaining count = DEPTH-1-PRE.
- CAPTURE:
  - Each valid sample is written and the remaining count decrements.
  - When the count is zero, enter DONE. If the count is zero on entry, enter DONE on the next cycle.
- DONE:
  - `status_done` = 1 and `status_addr` = current write address. Held until an arm edge or reset.
- Ignored events:
  - `trig` in IDLE, DELAY, CAPTURE or DONE.
  - `trig` without `din_we`.
- Simultaneous events:
  - An arm edge and `trig` in the same cycle: the arm wins and the trigger is ignored.
- Width rules:
  - Address arithmetic is modulo 2^AW.
  - The delay counter is 31-bit unsigned.
  - The remaining and fill counters are AW+1 bits.
  - The magnitude of -2^31 saturates to DEPTH-1.

## Timing
- The write path is registered: `bram_we`, `bram_addr` and `bram_data` are valid exactly 1 cycle after the qualifying `din_we`.
- `status_done` rises 1 cycle after the final `bram_we` pulse.
- Back-to-back `din_we` is supported at full rate with no stalls.
- The arm edge detector adds 1 cycle: a sample in the cycle after `arm` rises is already eligible for writing or triggering.
- Reset values:
  - All outputs 0, state IDLE, counters 0, edge-detect register 0.
  - Reset asserted mid-capture aborts immediately, with no partial `status_done`.

## Structure
- Package `snap_pkg` holds:
  - the state enum (IDLE, ARMED, DELAY, CAPTURE, DONE);
  - the offset width constant (32).
- One sub-module, `snap_edge_det`: a rising-edge detector with async active-low reset, used for `arm`.

## Test plan
- Bench settings: AW=4 (DEPTH 16), `din` = running count on valid samples.
- Offset 0, trig at din=5 -> mem[0..15] = 5..20; `status_done`=1; `status_addr`=0.
- Offset 3, trig at din=5 -> mem[0..15] = 8..23; exactly 16 `bram_we` pulses.
- Offset -4, arm at din=0, trig at din=10 -> last write din=21 at addr 5; `status_addr`=6; mem[6]=6, mem[5]=21.
- Offset -8, trig at din=3 -> ignored; trig at din=12 -> accepted; `status_addr`=4; mem[4]=4.
- `din_we` high 1 cycle in 3, offset 5 -> only valid samples counted; trig at din=2 -> mem[0]=7; `bram_we` lags each valid by 1 cycle.
- Robustness:
  - `user_rst_n` low during CAPTURE -> all outputs 0 immediately.
  - Re-arm during CAPTURE -> restarts at addr 0 and completes normally.
  - Arm edge and trig in the same cycle -> trigger ignored.

Source files
------------

// File: rtl/snap_pkg.sv
// snap_pkg: shared types and constants for the snapshot trigger/capture controller.
package snap_pkg;
    localparam int OFF_W = 32;
    typedef enum logic [2:0] {IDLE, ARMED, DELAY, CAPTURE, DONE} state_t;
endpackage

// File: rtl/snap_trig_capture_if.sv
// snap_trig_capture_if: sample/trigger inputs, BRAM write port and status outputs of the capture controller.
//   arm, trig_offset, trig, din_we, din           : control and sample stream into the controller
//   bram_we, bram_addr, bram_data                 : registered BRAM write port
//   status_done, status_addr                      : completion flag and oldest-sample address
interface snap_trig_capture_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          arm;
    logic [31:0]   trig_offset;
    logic          trig;
    logic          din_we;
    logic [DW-1:0] din;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data;
    logic          status_done;
    logic [AW-1:0] status_addr;

    modport master (
        output arm, trig_offset, trig, din_we, din,
        input  bram_we, bram_addr, bram_data, status_done, status_addr
    );
    modport slave (
        input  arm, trig_offset, trig, din_we, din,
        output bram_we, bram_addr, bram_data, status_done, status_addr
    );
endinterface

// File: rtl/snap_edge_det.sv
// snap_edge_det: rising-edge detector; rise is high while d is high and was low last cycle.
//   clk, rst_n : clock and async active-low reset
//   d          : level input
//   rise       : combinational edge pulse
module snap_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic prev_q, prev_d;

    always_comb prev_d = d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= prev_d;
    end

    assign rise = d & ~prev_q;
endmodule

// File: rtl/snap_trig_capture.sv
// snap_trig_capture: arms on an arm edge, waits for a valid trigger and writes a 2^AW-sample window to BRAM.
//   user_clk, user_rst_n : clock and async active-low reset
//   bus (slave)          : arm/offset/trigger/sample inputs, BRAM write port, status outputs
module snap_trig_capture
    import snap_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input logic                user_clk,
    input logic                user_rst_n,
    snap_trig_capture_if.slave bus
);
    localparam logic [AW:0] DEPTH   = (AW+1)'(1) << AW;
    localparam logic [AW:0] MAX_PRE = DEPTH - (AW+1)'(1);

    state_t           state_q, state_d;
    logic [OFF_W-1:0] off_q, off_d, mag;
    logic [OFF_W-2:0] dly_q, dly_d;
    logic [AW:0]      rem_q, rem_d, fill_q, fill_d, pre;
    logic [AW-1:0]    wr_addr_q, wr_addr_d, bram_addr_q, bram_addr_d, status_addr_q, status_addr_d;
    logic [DW-1:0]    bram_data_q, bram_data_d;
    logic             bram_we_q, bram_we_d, status_done_q, status_done_d;
    logic             arm_rise, neg, tv;

    snap_edge_det u_arm_edge (.clk(user_clk), .rst_n(user_rst_n), .d(bus.arm), .rise(arm_rise));

    always_comb begin
        tv            = bus.trig & bus.din_we;
        neg           = off_q[OFF_W-1];
        // |offset| as unsigned; -2^31 yields bit 31 set and so saturates like any other large value
        mag           = ~off_q + OFF_W'(1);
        pre           = (|mag[OFF_W-1:AW]) ? MAX_PRE : mag[AW:0];
        state_d       = state_q;
        off_d         = off_q;
        dly_d         = dly_q;
        rem_d         = rem_q;
        fill_d        = fill_q;
        wr_addr_d     = wr_addr_q;
        status_done_d = status_done_q;
        status_addr_d = status_addr_q;
        bram_we_d     = 1'b0;
        if (arm_rise) begin
            state_d       = ARMED;
            off_d         = bus.trig_offset;
            dly_d         = '0;
            rem_d         = '0;
            fill_d        = '0;
            wr_addr_d     = '0;
            status_done_d = 1'b0;
            status_addr_d = '0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (neg) begin
                        // pre-trigger history: every valid sample goes into the ring
                        if (bus.din_we) begin
                            bram_we_d = 1'b1;
                            fill_d    = (fill_q >= pre) ? fill_q : fill_q + (AW+1)'(1);
                            if (tv && fill_q >= pre) begin
                                state_d = CAPTURE;
                                rem_d   = MAX_PRE - pre;
                            end
                        end
                    end else if (tv) begin
                        if (off_q == '0) begin
                            bram_we_d = 1'b1;
                            state_d   = CAPTURE;
                            rem_d     = MAX_PRE;
                        end else begin
                            // trigger sample is the first discard; dly counts the discards still to come
                            dly_d   = off_q[OFF_W-2:0] - (OFF_W-1)'(1);
                            state_d = (off_q == OFF_W'(1)) ? CAPTURE : DELAY;
                            rem_d   = DEPTH;
                        end
                    end
                end
                DELAY: begin
                    if (bus.din_we) begin
                        dly_d = dly_q - (OFF_W-1)'(1);
                        if (dly_q == (OFF_W-1)'(1)) state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    // finishing on an empty count keeps status_done one cycle behind the last bram_we
                    if (rem_q == '0) begin
                        state_d       = DONE;
                        status_done_d = 1'b1;
                        status_addr_d = wr_addr_q;
                    end else if (bus.din_we) begin
                        bram_we_d = 1'b1;
                        rem_d     = rem_q - (AW+1)'(1);
                    end
                end
                default: ;
            endcase
        end
        if (bram_we_d) wr_addr_d = wr_addr_q + AW'(1);
        bram_addr_d = bram_we_d ? wr_addr_q : bram_addr_q;
        bram_data_d = bram_we_d ? bus.din : bram_data_q;
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q       <= IDLE;
            off_q         <= '0;
            dly_q         <= '0;
            rem_q         <= '0;
            fill_q        <= '0;
            wr_addr_q     <= '0;
            bram_we_q     <= 1'b0;
            bram_addr_q   <= '0;
            bram_data_q   <= '0;
            status_done_q <= 1'b0;
            status_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            off_q         <= off_d;
            dly_q         <= dly_d;
            rem_q         <= rem_d;
            fill_q        <= fill_d;
            wr_addr_q     <= wr_addr_d;
            bram_we_q     <= bram_we_d;
            bram_addr_q   <= bram_addr_d;
            bram_data_q   <= bram_data_d;
            status_done_q <= status_done_d;
            status_addr_q <= status_addr_d;
        end
    end

    assign bus.bram_we     = bram_we_q;
    assign bus.bram_addr   = bram_addr_q;
    assign bus.bram_data   = bram_data_q;
    assign bus.status_done = status_done_q;
    assign bus.status_addr = status_addr_q;
endmodule

// File: tb/tb_snap_trig_capture.sv
// tb_snap_trig_capture: directed table-driven bench for snap_trig_capture with AW=4.
module tb_snap_trig_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int cnt = 0;
    int we_cnt = 0;
    int lag_err = 0;
    logic [31:0] mem [16];
    logic prev_we = 1'b0;
    logic [31:0] prev_din = '0;

    typedef struct {
        int off; int trig; int trig2; int per;
        int sa; int we; int base;
        int a0; int d0; int a1; int d1;
    } vec_t;
    vec_t vecs [8];

    snap_trig_capture_if #(.AW(4), .DW(32)) bus ();
    snap_trig_capture #(.AW(4), .DW(32)) dut (.user_clk(clk), .user_rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    // BRAM model plus check that every write carries the sample presented one cycle earlier
    always @(negedge clk) begin
        if (bus.bram_we) begin
            mem[bus.bram_addr] = bus.bram_data;
            we_cnt++;
            if (!prev_we || bus.bram_data !== prev_din) lag_err++;
        end
        prev_we  = bus.din_we;
        prev_din = bus.din;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        for (int i = 0; i < 16; i++) mem[i] = 32'hffff_ffff;
        we_cnt  = 0;
        lag_err = 0;
        cnt     = 0;
    endtask

    task automatic do_arm(input int off);
        bus.arm = 1'b0;
        tick();
        bus.trig_offset = 32'(off);
        bus.arm = 1'b1;
        tick();
    endtask

    task automatic feed(input int trig, input int trig2, input int per, input int max, input bit stop);
        for (int c = 0; c < max; c++) begin
            if (stop && bus.status_done) break;
            if (c % per == 0) begin
                bus.din_we = 1'b1;
                bus.din    = 32'(cnt);
                bus.trig   = (cnt == trig) || (cnt == trig2);
            end else begin
                bus.din_we = 1'b0;
                bus.din    = 32'hdead_beef;
                bus.trig   = 1'b1;
            end
            tick();
            if (bus.din_we) cnt++;
        end
        bus.din_we = 1'b0;
        bus.trig   = 1'b0;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int bad;
        clear();
        do_arm(v.off);
        bus.trig_offset = 32'd7;
        feed(v.trig, v.trig2, v.per, 400, 1'b1);
        tick();
        tick();
        chk($sformatf("v%0d done", k), 32'(bus.status_done), 1);
        chk($sformatf("v%0d status_addr", k), 32'(bus.status_addr), 32'(v.sa));
        chk($sformatf("v%0d we_pulses", k), 32'(we_cnt), 32'(v.we));
        chk($sformatf("v%0d we_lag_errors", k), 32'(lag_err), 0);
        chk($sformatf("v%0d mem[%0d]", k, v.a0), mem[v.a0], 32'(v.d0));
        chk($sformatf("v%0d mem[%0d]", k, v.a1), mem[v.a1], 32'(v.d1));
        if (v.base >= 0) begin
            bad = 0;
            for (int i = 0; i < 16; i++) if (mem[i] !== 32'(v.base + i)) bad++;
            chk($sformatf("v%0d window_bad_entries", k), 32'(bad), 0);
        end
    endtask

    initial begin
        //          off                   trig trig2 per sa we  base a0 d0 a1 d1
        vecs[0] = '{0,                    5,   -1,   1,  0, 16, 5,   0, 5, 15, 20};
        vecs[1] = '{3,                    5,   -1,   1,  0, 16, 8,   0, 8, 15, 23};
        vecs[2] = '{-4,                   10,  -1,   1,  6, 22, -1,  6, 6, 5,  21};
        vecs[3] = '{-8,                   3,   12,   1,  4, 20, -1,  4, 4, 12, 12};
        vecs[4] = '{5,                    2,   -1,   3,  0, 16, 7,   0, 7, 15, 22};
        vecs[5] = '{-20,                  14,  15,   1,  0, 16, 0,   0, 0, 15, 15};
        vecs[6] = '{int'(32'h8000_0000),  20,  -1,   1,  5, 21, -1,  5, 5, 4,  20};
        vecs[7] = '{1,                    0,   -1,   1,  0, 16, 1,   0, 1, 15, 16};

        bus.arm = 1'b0; bus.trig_offset = '0; bus.trig = 1'b0; bus.din_we = 1'b0; bus.din = '0;
        tick();
        tick();
        chk("reset bram_we", 32'(bus.bram_we), 0);
        chk("reset bram_addr", 32'(bus.bram_addr), 0);
        chk("reset bram_data", bus.bram_data, 0);
        chk("reset status_done", 32'(bus.status_done), 0);
        chk("reset status_addr", 32'(bus.status_addr), 0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

        // async reset in the middle of a capture clears every output at once
        clear();
        do_arm(0);
        feed(5, -1, 1, 10, 1'b0);
        chk("pre-reset bram_we", 32'(bus.bram_we), 1);
        rst_n = 1'b0;
        #1;
        chk("mid-reset bram_we", 32'(bus.bram_we), 0);
        chk("mid-reset bram_addr", 32'(bus.bram_addr), 0);
        chk("mid-reset bram_data", bus.bram_data, 0);
        chk("mid-reset status_done", 32'(bus.status_done), 0);
        bus.arm = 1'b0;
        tick();
        rst_n = 1'b1;
        feed(-1, -1, 1, 20, 1'b0);
        chk("post-reset status_done", 32'(bus.status_done), 0);

        // re-arm during capture restarts from address 0
        clear();
        do_arm(0);
        feed(5, -1, 1, 8, 1'b0);
        do_arm(0);
        clear();
        feed(2, -1, 1, 400, 1'b1);
        tick();
        tick();
        chk("rearm done", 32'(bus.status_done), 1);
        chk("rearm we_pulses", 32'(we_cnt), 16);
        chk("rearm mem[0]", mem[0], 2);
        chk("rearm mem[15]", mem[15], 17);
        chk("rearm status_addr", 32'(bus.status_addr), 0);

        // arm edge and a valid trigger in the same cycle: the trigger is dropped
        clear();
        bus.arm = 1'b0;
        tick();
        bus.trig_offset = 32'd0;
        bus.arm = 1'b1;
        bus.din_we = 1'b1;
        bus.din = 32'd99;
        bus.trig = 1'b1;
        tick();
        bus.din_we = 1'b0;
        bus.trig = 1'b0;
        feed(-1, -1, 1, 20, 1'b0);
        tick();
        chk("arm+trig we_pulses", 32'(we_cnt), 0);
        chk("arm+trig status_done", 32'(bus.status_done), 0);
        feed(cnt, -1, 1, 400, 1'b1);
        tick();
        chk("arm+trig later done", 32'(bus.status_done), 1);
        chk("arm+trig later we_pulses", 32'(we_cnt), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
